// File: rtl/dino_game_pkg.sv
// Shared types, widths and default parameters for the runner game core.
package dino_game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } game_state_t;

   localparam int unsigned X_W = 11;
   localparam int unsigned Y_W = 10;

   localparam int unsigned N_OBST_DEF       = 3;
   localparam int unsigned SCREEN_W_DEF     = 640;
   localparam int unsigned OBST_SPACING_DEF = 240;
   localparam int unsigned DINO_X_DEF       = 320;
   localparam int unsigned GROUND_Y_DEF     = 240;
   localparam int unsigned JUMP_V_DEF       = 12;
   localparam int unsigned GRAVITY_DEF      = 1;
   localparam int unsigned SPEED_INIT_DEF   = 2;
   localparam int unsigned SPEED_MAX_DEF    = 8;
   localparam int unsigned SPEED_STEP_DEF   = 10;
   localparam int unsigned OVER_HOLDOFF_DEF = 30;

   // The obstacle ring must be at least a screen wide or obstacles reappear on-screen.
   function automatic bit pitch_covers_screen(input int unsigned n, input int unsigned pitch,
                                              input int unsigned width);
      return (n * pitch) >= width;
   endfunction

endpackage

// File: rtl/dino_game_core_bcd_counter4.sv
// Four-digit BCD counter that increments by one per inc pulse and holds at 9999.
module bcd_counter4 (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        inc,
   output logic [15:0] value,
   output logic        sat
);

   logic [15:0] value_next;
   logic        carry;

   always_comb begin
      value_next = value;
      carry      = 1'b1;
      for (int unsigned d = 0; d < 4; d++) begin
         if (carry) begin
            if (value[4*d +: 4] == 4'd9) begin
               value_next[4*d +: 4] = 4'd0;
            end else begin
               value_next[4*d +: 4] = value[4*d +: 4] + 4'd1;
               carry                = 1'b0;
            end
         end
      end
      sat = (value == 16'h9999);
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         value <= '0;
      end else if (inc && !sat) begin
         value <= value_next;
      end
   end

endmodule

// File: rtl/dino_game_core.sv
// Runner game engine: jump physics, N wrapping obstacles, BCD scoring with
// speed ramp, and hit-driven game over with a restart holdoff.
module dino_game_core
   import dino_game_pkg::*;
#(
   parameter int unsigned N_OBST       = N_OBST_DEF,
   parameter int unsigned SCREEN_W     = SCREEN_W_DEF,
   parameter int unsigned OBST_SPACING = OBST_SPACING_DEF,
   parameter int unsigned DINO_X       = DINO_X_DEF,
   parameter int unsigned GROUND_Y     = GROUND_Y_DEF,
   parameter int unsigned JUMP_V       = JUMP_V_DEF,
   parameter int unsigned GRAVITY      = GRAVITY_DEF,
   parameter int unsigned SPEED_INIT   = SPEED_INIT_DEF,
   parameter int unsigned SPEED_MAX    = SPEED_MAX_DEF,
   parameter int unsigned SPEED_STEP   = SPEED_STEP_DEF,
   parameter int unsigned OVER_HOLDOFF = OVER_HOLDOFF_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_tick,
   input  logic                  jump_btn,
   input  logic                  hit,
   output logic [Y_W-1:0]        dino_y,
   output logic [N_OBST*X_W-1:0] obst_x,
   output logic [15:0]           score,
   output logic [3:0]            speed,
   output logic [1:0]            game_state
);

   localparam int unsigned VEL_W  = 8;
   localparam int unsigned HOLD_W = $clog2(OVER_HOLDOFF + 1);
   localparam int unsigned STEP_W = $clog2(SPEED_STEP + 1);
   localparam int unsigned PEND_W = 3;

   localparam logic [X_W-1:0]   WRAP_X   = X_W'(N_OBST * OBST_SPACING);
   localparam logic [X_W-1:0]   DINO_XV  = X_W'(DINO_X);
   localparam logic [X_W-1:0]   GROUND_X = X_W'(GROUND_Y);
   localparam logic [Y_W-1:0]   GROUND   = Y_W'(GROUND_Y);
   localparam logic [VEL_W-1:0] LAUNCH_V = VEL_W'(0) - VEL_W'(JUMP_V);

   if (!pitch_covers_screen(N_OBST, OBST_SPACING, SCREEN_W) || N_OBST < 1 || N_OBST > 4)
   begin : g_cfg_check
      $error("dino_game_core: N_OBST must be 1..4 and N_OBST*OBST_SPACING >= SCREEN_W");
   end

   game_state_t state, state_next;

   logic              prev_btn;
   logic              press;
   logic              holdoff_full;
   logic              restart;
   logic [Y_W-1:0]    y_q;
   logic [VEL_W-1:0]  vel;
   logic              airborne;
   logic [X_W-1:0]    obst      [N_OBST];
   logic [X_W-1:0]    obst_next [N_OBST];
   logic [X_W-1:0]    y_sum;
   logic [X_W-1:0]    speed_x;
   logic [3:0]        speed_q;
   logic [HOLD_W-1:0] holdoff;
   logic [STEP_W-1:0] step_cnt;
   logic [PEND_W-1:0] pending;
   logic [PEND_W-1:0] n_cross;
   logic              score_inc;
   logic              score_sat;

   always_comb begin
      press        = jump_btn & ~prev_btn;
      holdoff_full = (holdoff == HOLD_W'(OVER_HOLDOFF));
      score_inc    = (pending != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (press) state_next = RUN;
         RUN:     if (hit) state_next = OVER;
         OVER:    if (press && holdoff_full) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      game_state = state;
      restart    = (state == OVER) && press && holdoff_full;
   end

   always_comb begin
      y_sum   = {1'b0, y_q} + {{(X_W-VEL_W){vel[VEL_W-1]}}, vel};
      speed_x = X_W'(speed_q);
      n_cross = '0;
      obst_next = obst;
      for (int unsigned i = 0; i < N_OBST; i++) begin
         if (obst[i] <= speed_x) begin
            obst_next[i] = obst[i] + WRAP_X - speed_x;
         end else begin
            obst_next[i] = obst[i] - speed_x;
         end
         if (obst[i] >= DINO_XV && (obst[i] - speed_x) < DINO_XV) begin
            n_cross = n_cross + PEND_W'(1);
         end
      end
   end

   // Crossings found on a frame are queued and fed to the BCD counter one per
   // cycle, so simultaneous crossings each count and the ramp sees every point.
   always_ff @(posedge clk) begin
      prev_btn <= jump_btn;
      if (reset || restart) begin
         y_q      <= GROUND;
         vel      <= '0;
         airborne <= 1'b0;
         for (int unsigned i = 0; i < N_OBST; i++) begin
            obst[i] <= X_W'(SCREEN_W + i * OBST_SPACING);
         end
         speed_q  <= 4'(SPEED_INIT);
         holdoff  <= '0;
         step_cnt <= '0;
         pending  <= '0;
      end else begin
         if (state == RUN && frame_tick && airborne) begin
            vel <= vel + VEL_W'(GRAVITY);
            if (y_sum[X_W-1]) begin
               y_q <= '0;
            end else if (y_sum >= GROUND_X) begin
               y_q      <= GROUND;
               vel      <= '0;
               airborne <= 1'b0;
            end else begin
               y_q <= y_sum[Y_W-1:0];
            end
         end else if (state != OVER && press && !airborne) begin
            vel      <= LAUNCH_V;
            airborne <= 1'b1;
         end

         if (state == RUN && frame_tick) begin
            obst <= obst_next;
         end

         if (state == OVER && frame_tick && !holdoff_full) begin
            holdoff <= holdoff + HOLD_W'(1);
         end

         pending <= pending - PEND_W'(score_inc)
                    + ((state == RUN && frame_tick) ? n_cross : PEND_W'(0));

         if (score_inc && !score_sat) begin
            if (step_cnt == STEP_W'(SPEED_STEP - 1)) begin
               step_cnt <= '0;
               if (speed_q < 4'(SPEED_MAX)) begin
                  speed_q <= speed_q + 4'd1;
               end
            end else begin
               step_cnt <= step_cnt + STEP_W'(1);
            end
         end
      end
   end

   bcd_counter4 u_score (
      .clk   (clk),
      .reset (reset),
      .clear (restart),
      .inc   (score_inc),
      .value (score),
      .sat   (score_sat)
   );

   for (genvar g = 0; g < N_OBST; g++) begin : g_obst_out
      assign obst_x[X_W*g +: X_W] = obst[g];
   end

   assign dino_y = y_q;
   assign speed  = speed_q;

endmodule

// File: tb/tb_dino_game_core.sv
// Randomized bench for dino_game_core against an integer game model.
module tb_dino_game_core;

   localparam int N  = 3;
   localparam int SW = 640;
   localparam int SP = 240;
   localparam int DX = 320;
   localparam int GY = 240;
   localparam int JV = 12;
   localparam int GR = 1;
   localparam int SI = 2;
   localparam int SM = 8;
   localparam int SS = 10;
   localparam int OH = 30;

   logic            clk = 1'b0;
   logic            reset;
   logic            frame_tick;
   logic            jump_btn;
   logic            hit;
   logic [9:0]      dino_y;
   logic [N*11-1:0] obst_x;
   logic [15:0]     score;
   logic [3:0]      speed;
   logic [1:0]      game_state;

   dino_game_core #(
      .N_OBST(N), .SCREEN_W(SW), .OBST_SPACING(SP), .DINO_X(DX), .GROUND_Y(GY),
      .JUMP_V(JV), .GRAVITY(GR), .SPEED_INIT(SI), .SPEED_MAX(SM),
      .SPEED_STEP(SS), .OVER_HOLDOFF(OH)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .jump_btn(jump_btn), .hit(hit),
      .dino_y(dino_y), .obst_x(obst_x), .score(score), .speed(speed),
      .game_state(game_state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: 0=IDLE 1=RUN 2=OVER, plain integer positions and score.
   int m_state, m_y, m_vel, m_score, m_hold;
   bit m_air, m_prev;
   int m_obst [N];
   int since = 99;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int model_speed();
      int s = SI + m_score / SS;
      return (s > SM) ? SM : s;
   endfunction

   function automatic bit rnd(input int pct);
      return $urandom_range(0, 99) < pct;
   endfunction

   function automatic int obst_out(input int i);
      logic [N*11-1:0] v = obst_x;
      return int'(v[11*i +: 11]);
   endfunction

   task automatic model_init();
      m_state = 0; m_y = GY; m_vel = 0; m_air = 0; m_score = 0; m_hold = 0;
      for (int i = 0; i < N; i++) m_obst[i] = SW + i * SP;
   endtask

   task automatic model_step(input bit b, input bit t, input bit h);
      bit pr = b && !m_prev;
      m_prev = b;
      case (m_state)
         0: if (pr) begin m_state = 1; m_vel = -JV; m_air = 1; end
         1: begin
            if (t && m_air) begin
               m_y = m_y + m_vel;
               m_vel = m_vel + GR;
               if (m_y < 0) m_y = 0;
               if (m_y >= GY) begin m_y = GY; m_vel = 0; m_air = 0; end
            end else if (pr && !m_air) begin
               m_vel = -JV; m_air = 1;
            end
            if (t) begin
               int sp = model_speed();
               int c = 0;
               for (int i = 0; i < N; i++) begin
                  if (m_obst[i] >= DX && m_obst[i] - sp < DX) c++;
                  m_obst[i] = (m_obst[i] <= sp) ? m_obst[i] + N * SP - sp : m_obst[i] - sp;
               end
               m_score = (m_score + c > 9999) ? 9999 : m_score + c;
            end
            if (h) m_state = 2;
         end
         default: begin
            if (pr && m_hold >= OH) model_init();
            else if (t && m_hold < OH) m_hold++;
         end
      endcase
   endtask

   task automatic compare_all();
      check_eq("state", 32'(game_state), 32'(m_state));
      check_eq("dino_y", 32'(dino_y), 32'(m_y));
      for (int i = 0; i < N; i++) check_eq($sformatf("obst_x%0d", i), 32'(obst_out(i)), 32'(m_obst[i]));
      if (since >= 4) begin
         check_eq("score", 32'(score), 32'(to_bcd(m_score)));
         check_eq("speed", 32'(speed), 32'(model_speed()));
      end
   endtask

   task automatic cycle(input bit b, input bit t, input bit h);
      jump_btn = b; frame_tick = t; hit = h;
      @(posedge clk);
      if (reset) begin
         model_init();
         m_prev = b;
         since = 99;
      end else begin
         model_step(b, t, h);
         since = t ? 0 : since + 1;
      end
      #1;
      compare_all();
   endtask

   task automatic frame(input int press_pct, input int hit_pct);
      cycle(rnd(press_pct), 1'b1, rnd(hit_pct));
      repeat ($urandom_range(5, 7)) cycle(rnd(press_pct), 1'b0, rnd(hit_pct));
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_state"}, 32'(game_state), 32'd0);
      check_eq({tag, "_y"}, 32'(dino_y), 32'd240);
      check_eq({tag, "_o0"}, 32'(obst_out(0)), 32'd640);
      check_eq({tag, "_o1"}, 32'(obst_out(1)), 32'd880);
      check_eq({tag, "_o2"}, 32'(obst_out(2)), 32'd1120);
      check_eq({tag, "_score"}, 32'(score), 32'h0000);
      check_eq({tag, "_speed"}, 32'(speed), 32'd2);
   endtask

   initial begin
      int cap_y, cap_o0, cap_o2;
      bit seen10 = 0;
      reset = 1'b1; jump_btn = 1'b0; frame_tick = 1'b0; hit = 1'b0;
      repeat (3) cycle(0, 0, 0);
      reset = 1'b0;
      check_reset_values("rst");

      // IDLE: ticks and hits move nothing
      repeat (3) frame(0, 30);
      check_reset_values("idle");

      cycle(1, 0, 0);
      cycle(0, 0, 0);
      check_eq("start_state", 32'(game_state), 32'd1);

      for (int f = 1; f <= 330; f++) begin
         cycle((f > 25) && rnd(20), 1'b1, 1'b0);
         if (f == 1)   check_eq("jump_f1", 32'(dino_y), 32'd228);
         if (f == 12)  check_eq("jump_apex", 32'(dino_y), 32'd162);
         if (f == 25)  check_eq("jump_land", 32'(dino_y), 32'd240);
         if (f < 320)  check_eq("obst0_lin", 32'(obst_out(0)), 32'(640 - 2 * f));
         if (f == 320) check_eq("obst0_wrap", 32'(obst_out(0)), 32'd720);
         repeat ($urandom_range(5, 7)) cycle((f > 25) && rnd(20), 1'b0, 1'b0);
         if (f == 160) check_eq("score_160", 32'(score), 32'h0000);
         if (f == 161) check_eq("score_161", 32'(score), 32'h0001);
      end
      check_eq("run_state", 32'(game_state), 32'd1);

      for (int f = 0; f < 5000 && m_score < 62; f++) begin
         frame(15, 0);
         if (!seen10 && m_score >= 10) begin
            seen10 = 1;
            check_eq("speed_at_10", 32'(speed), 32'd3);
         end
      end
      check_eq("speed_cap", 32'(speed), 32'd8);
      check_eq("score_ge_60", 32'(score >= 16'h0060), 32'd1);

      // hit mid-jump, then freeze
      for (int k = 0; k < 60 && m_air; k++) frame(0, 0);
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      repeat (4) frame(0, 0);
      cycle(0, rnd(50), 1);
      check_eq("hit_state", 32'(game_state), 32'd2);
      cap_y = m_y; cap_o0 = m_obst[0]; cap_o2 = m_obst[2];
      repeat (5) frame(0, 30);
      check_eq("frozen_y", 32'(dino_y), 32'(cap_y));
      check_eq("frozen_o0", 32'(obst_out(0)), 32'(cap_o0));
      check_eq("frozen_o2", 32'(obst_out(2)), 32'(cap_o2));

      repeat (5) frame(0, 30);
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      check_eq("over_press10", 32'(game_state), 32'd2);
      repeat (19) frame(0, 30);
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      check_eq("over_press29", 32'(game_state), 32'd2);
      frame(0, 30);
      cycle(1, 0, 0);
      check_reset_values("restart");
      cycle(0, 0, 0);

      // button held through reset release is not a press
      reset = 1'b1;
      repeat (2) cycle(1, 0, 0);
      reset = 1'b0;
      repeat (3) cycle(1, 0, 0);
      check_eq("held_idle", 32'(game_state), 32'd0);
      cycle(0, 0, 0);
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      check_eq("held_run", 32'(game_state), 32'd1);
      repeat (3) frame(0, 0);
      check_eq("midjump_y", 32'(dino_y), 32'd207);
      reset = 1'b1;
      cycle(0, 0, 0);
      reset = 1'b0;
      check_reset_values("midreset");

      repeat (150) frame(15, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
